// File: rtl/rsa_block_sequencer_pkg.sv
// rtl/rsa_block_sequencer_pkg.sv - shared types, width defaults and watchdog limit for the RSA block sequencer
package rsa_block_sequencer_pkg;

    localparam int DEF_WIDTH_DEG   = 8;
    localparam int DEF_WIDTH_N     = 8;
    localparam int DEF_WIDTH_MSG_I = 8;
    localparam int DEF_FIFO_DEPTH  = 4;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        LOAD,
        RUN,
        DONE
    } state_t;

    // Longest legal run is 2**WIDTH_DEG-1 enabel cycles; allow a small margin before giving up.
    function automatic int watchdog_max(input int width_deg);
        return (1 << width_deg) + 2;
    endfunction

    // Counter width that can hold watchdog_max(width_deg).
    function automatic int watchdog_width(input int width_deg);
        return width_deg + 2;
    endfunction

endpackage

// File: rtl/rsa_block_sequencer_if.sv
// rtl/rsa_block_sequencer_if.sv - message input stream and result output stream of the sequencer
interface rsa_block_sequencer_if #(
    parameter int WIDTH_MSG_I = 8,
    parameter int WIDTH_N     = 8
);

    logic [WIDTH_MSG_I-1:0] s_data;
    logic                   s_valid;
    logic                   s_ready;

    logic [WIDTH_N-1:0]     m_data;
    logic                   m_err;
    logic                   m_valid;
    logic                   m_ready;

    // Producer of messages and consumer of results.
    modport master (
        output s_data,
        output s_valid,
        input  s_ready,
        input  m_data,
        input  m_err,
        input  m_valid,
        output m_ready
    );

    // The sequencer itself.
    modport slave (
        input  s_data,
        input  s_valid,
        output s_ready,
        output m_data,
        output m_err,
        output m_valid,
        input  m_ready
    );

endinterface

// File: rtl/rsa_block_sequencer_word_fifo.sv
// rtl/rsa_block_sequencer_word_fifo.sv - synchronous word FIFO buffering messages ahead of the core
module rsa_word_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign count    = wr_ptr - rd_ptr;
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Advance read and write pointers; a simultaneous push and pop both take effect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage array needs no reset; only words behind the write pointer are ever read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/rsa_block_sequencer.sv
// rtl/rsa_block_sequencer.sv - front/back-end controller feeding words to the modular-exponentiation core
module rsa_block_sequencer
    import rsa_block_sequencer_pkg::*;
#(
    parameter int WIDTH_DEG   = DEF_WIDTH_DEG,
    parameter int WIDTH_N     = DEF_WIDTH_N,
    parameter int WIDTH_MSG_I = DEF_WIDTH_MSG_I,
    parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   key_load,
    input  logic [WIDTH_DEG-1:0]   key_e,
    input  logic [WIDTH_N-1:0]     key_n,
    output logic                   key_busy,

    rsa_block_sequencer_if.slave   bus,

    output logic                   core_enabel,
    output logic                   core_start,
    output logic [WIDTH_MSG_I-1:0] core_in,
    output logic [WIDTH_DEG-1:0]   core_degree,
    output logic [WIDTH_N-1:0]     core_n,
    input  logic [WIDTH_N-1:0]     core_out,
    input  logic                   core_down
);

    localparam int CW     = WIDTH_MSG_I + WIDTH_N;
    localparam int WD_MAX = watchdog_max(WIDTH_DEG);
    localparam int WD_W   = watchdog_width(WIDTH_DEG);
    localparam int FAW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    state_t                 state;
    state_t                 state_next;

    logic [WIDTH_DEG-1:0]   e_r;
    logic [WIDTH_N-1:0]     n_r;
    logic [WIDTH_MSG_I-1:0] msg_r;
    logic [WD_W-1:0]        wd_cnt;

    logic [WIDTH_N-1:0]     m_data_r;
    logic                   m_err_r;
    logic                   m_valid_r;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [WIDTH_MSG_I-1:0] fifo_head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [FAW:0]           fifo_count;

    logic [CW-1:0]          msg_ext;
    logic [CW-1:0]          n_ext;
    logic [CW-1:0]          rem_ext;
    logic                   msg_too_big;
    logic                   wd_expired;

    logic                   result_load;
    logic [WIDTH_N-1:0]     result_data;
    logic                   result_err;

    // Held at 0 during reset so nothing upstream believes a word was taken.
    assign bus.s_ready = rst_n & ~fifo_full;
    assign fifo_push   = bus.s_valid & bus.s_ready;

    rsa_word_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WIDTH_MSG_I)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (bus.s_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // The key may only change when no word is in flight or waiting, so every result uses one key.
    assign key_busy    = (state != IDLE) || (fifo_count != '0);
    assign core_degree = e_r;
    assign core_n      = n_r;
    assign core_in     = msg_r;
    assign core_start  = (state == LOAD);
    assign core_enabel = (state == RUN);

    assign bus.m_data  = m_data_r;
    assign bus.m_err   = m_err_r;
    assign bus.m_valid = m_valid_r;

    // Compare and reduce in a common width so unequal message/modulus widths stay correct.
    assign msg_ext     = CW'(msg_r);
    assign n_ext       = CW'(n_r);
    assign msg_too_big = (msg_ext >= n_ext);
    assign rem_ext     = (n_ext == '0) ? '0 : (msg_ext % n_ext);
    assign wd_expired  = (wd_cnt == WD_W'(WD_MAX - 1));

    // Next-state and result selection for the word sequencer.
    always_comb begin
        state_next  = state;
        fifo_pop    = 1'b0;
        result_load = 1'b0;
        result_data = '0;
        result_err  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty && !m_valid_r) begin
                    fifo_pop   = 1'b1;
                    state_next = CHECK;
                end
            end
            CHECK: begin
                if (msg_too_big) begin
                    result_load = 1'b1;
                    result_err  = 1'b1;
                    state_next  = DONE;
                end else if (e_r == '0) begin
                    result_load = 1'b1;
                    result_data = (n_r == WIDTH_N'(1)) ? '0 : WIDTH_N'(1);
                    state_next  = DONE;
                end else if (e_r == WIDTH_DEG'(1)) begin
                    result_load = 1'b1;
                    result_data = WIDTH_N'(rem_ext);
                    state_next  = DONE;
                end else begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = RUN;
            end
            RUN: begin
                if (core_down) begin
                    result_load = 1'b1;
                    result_data = core_out;
                    state_next  = DONE;
                end else if (wd_expired) begin
                    result_load = 1'b1;
                    result_err  = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                if (m_valid_r && bus.m_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the head word as it leaves the FIFO; it stays on core_in until the next pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msg_r <= '0;
        end else if (fifo_pop) begin
            msg_r <= fifo_head;
        end
    end

    // Key registers; a load request while busy is dropped, not deferred.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_r <= '0;
            n_r <= '0;
        end else if (key_load && !key_busy) begin
            e_r <= key_e;
            n_r <= key_n;
        end
    end

    // Watchdog counts cycles spent in RUN and restarts from zero for every run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
        end else if (state == RUN) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    // Result register: loaded once per word, held valid until the consumer accepts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data_r  <= '0;
            m_err_r   <= 1'b0;
            m_valid_r <= 1'b0;
        end else if (result_load) begin
            m_data_r  <= result_data;
            m_err_r   <= result_err;
            m_valid_r <= 1'b1;
        end else if (m_valid_r && bus.m_ready) begin
            m_valid_r <= 1'b0;
        end
    end

endmodule
